// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response channel plus the BRAM port of the load/store controller.
// The slave modport is the controller; the master modport is the CPU and BRAM wrapper around it.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_wren;
  logic [31:0] mem_dout;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_dout,
    output req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_din, mem_wren
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_dout,
    input  req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_din, mem_wren
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store controller: byte/half/word accesses on a word-wide BRAM, sub-word stores done
// as read-modify-write, loads lane-extracted and sign/zero-extended, bad requests rejected.
module mem_access_ctrl #(
  parameter int ADDR_W = 13
) (
  input  logic          clk,
  input  logic          rst,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DATA,
    S_WRITE,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  state_t      state, state_nx;

  logic        we_q;
  logic        sgn_q;
  logic        err_q;
  size_t       size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] data_q;

  logic        accept;
  logic        req_err;
  logic        wren;
  logic [31:0] word_addr;
  logic [4:0]  lane_sh;
  logic [15:0] lane_dout;
  logic [31:0] lane_mask;
  logic [31:0] merged;
  logic [31:0] load_val;

  assign accept    = (state == S_IDLE) && bus.req_valid;
  assign word_addr = {addr_q[31:2], 2'b00};
  assign lane_sh   = {addr_q[1:0], 3'b000};

  // Any failing check rejects the request, so the checks can be OR-ed together.
  always_comb begin
    req_err = |bus.req_addr[31:ADDR_W];
    case (bus.req_size)
      SZ_HALF: req_err = req_err | bus.req_addr[0];
      SZ_WORD: req_err = req_err | (|bus.req_addr[1:0]);
      SZ_RSVD: req_err = 1'b1;
      default: ;
    endcase
  end

  // Lane extraction and merge both work on the word returned by the read in DATA.
  always_comb begin
    lane_dout = 16'(bus.mem_dout >> lane_sh);
    lane_mask = (size_q == SZ_BYTE) ? (32'h0000_00FF << lane_sh) : (32'h0000_FFFF << lane_sh);
    merged    = (bus.mem_dout & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
    case (size_q)
      SZ_BYTE: load_val = {{24{sgn_q & lane_dout[7]}}, lane_dout[7:0]};
      SZ_HALF: load_val = {{16{sgn_q & lane_dout[15]}}, lane_dout[15:0]};
      default: load_val = bus.mem_dout;
    endcase
  end

  // NOTE: registers are updated with <= so every flop samples the pre-edge values of its inputs.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // NOTE: the request/data registers carry no reset; every output they feed is gated by state.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.req_we;
      size_q  <= size_t'(bus.req_size);
      sgn_q   <= bus.req_signed;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      err_q   <= req_err;
      data_q  <= bus.req_wdata;
    end else if (state == S_DATA) begin
      data_q  <= we_q ? merged : load_val;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves a latch behind.
  always_comb begin
    state_nx       = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_rdata = '0;
    bus.mem_addr   = '0;
    bus.mem_din    = '0;
    wren           = 1'b0;
    case (state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (req_err)                                 state_nx = S_RESP;
          else if (bus.req_we && bus.req_size == SZ_WORD) state_nx = S_WRITE;
          else                                         state_nx = S_READ;
        end
      end
      S_READ: begin
        bus.mem_addr = word_addr;
        state_nx     = S_DATA;
      end
      S_DATA: begin
        state_nx = we_q ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        bus.mem_addr = word_addr;
        bus.mem_din  = data_q;
        wren         = 1'b1;
        state_nx     = S_RESP;
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
        bus.resp_rdata = (err_q || we_q) ? '0 : data_q;
        state_nx       = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // A reset landing in the WRITE cycle must not reach the BRAM.
  assign bus.mem_wren = wren & ~rst;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: BRAM model, byte-level reference model with an every-cycle
// compare process, and directed vectors carrying hand-computed expectations.
module tb_mem_access_ctrl;
  localparam int ADDR_W = 13;
  localparam int WORDS  = 1 << (ADDR_W - 2);

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // BRAM wrapper: address sampled at the edge, data valid the following cycle.
  logic [31:0] bram    [WORDS];
  logic [31:0] ref_mem [WORDS];

  always @(posedge clk) begin
    if (bus.mem_wren) bram[bus.mem_addr[ADDR_W-1:2]] <= bus.mem_din;
    bus.mem_dout <= bram[bus.mem_addr[ADDR_W-1:2]];
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rdata;
    int          acc;
  } resp_exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] din;
  } wr_exp_t;

  resp_exp_t rq[$];
  wr_exp_t   wq[$];

  int cyc        = 0;
  bit model_idle = 1'b1;
  int done_cyc   = 0;
  int acc_cnt    = 0;
  int resp_cnt   = 0;
  int wren_cnt   = 0;

  logic        last_err;
  logic [31:0] last_rdata;
  int          last_lat;
  logic [31:0] last_wr_addr;
  logic [31:0] last_wr_din;

  // Cycle k after the accept edge is the cycle with cyc == accept_cyc + k - 1.
  task automatic model_accept();
    logic [31:0] a   = bus.req_addr;
    logic [31:0] wd  = bus.req_wdata;
    logic [1:0]  sz  = bus.req_size;
    logic        we  = bus.req_we;
    logic        sgn = bus.req_signed;
    logic        err;
    logic [31:0] rd  = '0;
    logic [31:0] w;
    logic [31:0] nw;
    logic [7:0]  b [4];
    int          lat;
    int          off;
    err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
          || ((a >> ADDR_W) != 0);
    if (err) begin
      lat = 1;
    end else begin
      off = int'(a[1:0]);
      w   = ref_mem[a[ADDR_W-1:2]];
      for (int k = 0; k < 4; k++) b[k] = w[8*k +: 8];
      if (!we) begin
        lat = 3;
        case (sz)
          2'b00: begin
            rd = {24'h0, b[off]};
            if (sgn && b[off][7]) rd = rd | 32'hFFFF_FF00;
          end
          2'b01: begin
            rd = {16'h0, b[off+1], b[off]};
            if (sgn && b[off+1][7]) rd = rd | 32'hFFFF_0000;
          end
          default: rd = w;
        endcase
      end else begin
        if (sz == 2'b10) begin
          lat = 2;
          nw  = wd;
        end else begin
          lat    = 4;
          b[off] = wd[7:0];
          if (sz == 2'b01) b[off+1] = wd[15:8];
          nw = {b[3], b[2], b[1], b[0]};
        end
        wq.push_back('{cyc: cyc + lat - 2, addr: {a[31:2], 2'b00}, din: nw});
      end
    end
    rq.push_back('{cyc: cyc + lat - 1, err: err, rdata: rd, acc: cyc});
    done_cyc   = cyc + lat - 1;
    model_idle = 1'b0;
    acc_cnt++;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      model_idle = 1'b1;
      rq.delete();
      wq.delete();
    end else if (model_idle) begin
      if (bus.req_valid) model_accept();
    end else if (cyc == done_cyc + 1) begin
      model_idle = 1'b1;
    end
  end

  // Compare process: every output, every cycle, mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      check("wren_in_rst", 32'(bus.mem_wren), 0);
      rq.delete();
      wq.delete();
    end else begin
      check("req_ready", 32'(bus.req_ready), 32'(model_idle));
      if (bus.mem_wren) begin
        wren_cnt++;
        last_wr_addr = bus.mem_addr;
        last_wr_din  = bus.mem_din;
      end
      if (wq.size() > 0 && wq[0].cyc == cyc) begin
        check("mem_wren", 32'(bus.mem_wren), 1);
        check("mem_addr", bus.mem_addr, wq[0].addr);
        check("mem_din", bus.mem_din, wq[0].din);
        ref_mem[wq[0].addr[ADDR_W-1:2]] = wq[0].din;
        void'(wq.pop_front());
      end else begin
        check("mem_wren_idle", 32'(bus.mem_wren), 0);
      end
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        check("resp_valid", 32'(bus.resp_valid), 1);
        check("resp_err", 32'(bus.resp_err), 32'(rq[0].err));
        check("resp_rdata", bus.resp_rdata, rq[0].rdata);
        last_err   = bus.resp_err;
        last_rdata = bus.resp_rdata;
        last_lat   = cyc - rq[0].acc + 1;
        resp_cnt++;
        void'(rq.pop_front());
      end else begin
        check("resp_valid_idle", 32'(bus.resp_valid), 0);
        check("resp_err_idle", 32'(bus.resp_err), 0);
        check("resp_rdata_idle", bus.resp_rdata, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] a, input logic [31:0] wd);
    int a0 = acc_cnt;
    int n  = 0;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = sz;
    bus.req_signed = sgn;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    while (acc_cnt == a0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("accept_seen", 32'(acc_cnt - a0), 1);
  endtask

  task automatic wait_resp(input int target);
    int n = 0;
    while (resp_cnt < target && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("resp_seen", resp_cnt, target);
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] a, input logic [31:0] wd);
    int r0 = resp_cnt;
    issue(we, sz, sgn, a, wd);
    bus.req_valid = 1'b0;
    wait_resp(r0 + 1);
  endtask

  task automatic tv(input string name, input logic we, input logic [1:0] sz, input logic sgn,
                    input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                    input logic exp_err, input int exp_lat);
    int wc = wren_cnt;
    do_req(we, sz, sgn, a, wd);
    check({name, ".err"}, 32'(last_err), 32'(exp_err));
    check({name, ".rdata"}, last_rdata, exp_rd);
    check({name, ".lat"}, last_lat, exp_lat);
    if (exp_err) check({name, ".no_write"}, wren_cnt, wc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    int rc;
    for (int i = 0; i < WORDS; i++) begin
      bram[i] = {8'(i), 8'(i + 1), 8'(~i), 8'(i * 3)};
    end
    bram[32'h40] = 32'h1122_3344;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = bram[i];

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.req_ready", 32'(bus.req_ready), 1);
    check("rst.resp_valid", 32'(bus.resp_valid), 0);
    check("rst.resp_err", 32'(bus.resp_err), 0);
    check("rst.resp_rdata", bus.resp_rdata, 0);
    check("rst.mem_wren", 32'(bus.mem_wren), 0);
    check("rst.mem_addr", bus.mem_addr, 0);
    check("rst.mem_din", bus.mem_din, 0);
    rst = 1'b0;

    // Byte store read-modify-write
    wc = wren_cnt;
    tv("sb_102", 1'b1, 2'b00, 1'b0, 32'h102, 32'h0000_00AB, 32'h0, 1'b0, 4);
    check("sb_102.wren_pulses", wren_cnt - wc, 1);
    check("sb_102.wr_addr", last_wr_addr, 32'h100);
    check("sb_102.wr_din", last_wr_din, 32'h11AB_3344);
    check("sb_102.bram", bram[32'h40], 32'h11AB_3344);
    check("sb_102.model", ref_mem[32'h40], 32'h11AB_3344);

    // Loads from the merged word
    tv("lb_s_102", 1'b0, 2'b00, 1'b1, 32'h102, 32'h0, 32'hFFFF_FFAB, 1'b0, 3);
    tv("lb_u_102", 1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 32'h0000_00AB, 1'b0, 3);
    tv("lh_s_102", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h0000_11AB, 1'b0, 3);
    tv("lw_100",   1'b0, 2'b10, 1'b1, 32'h100, 32'h0, 32'h11AB_3344, 1'b0, 3);

    // Word store at the top of the range, then sub-word views of it
    tv("sw_1ffc",   1'b1, 2'b10, 1'b0, 32'h1FFC, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
    check("sw_1ffc.wr_addr", last_wr_addr, 32'h1FFC);
    tv("lw_1ffc",   1'b0, 2'b10, 1'b0, 32'h1FFC, 32'h0, 32'hDEAD_BEEF, 1'b0, 3);
    tv("lh_s_1ffe", 1'b0, 2'b01, 1'b1, 32'h1FFE, 32'h0, 32'hFFFF_DEAD, 1'b0, 3);
    tv("lb_u_1ffd", 1'b0, 2'b00, 1'b0, 32'h1FFD, 32'h0, 32'h0000_00BE, 1'b0, 3);
    tv("lb_s_1ffc", 1'b0, 2'b00, 1'b1, 32'h1FFC, 32'h0, 32'hFFFF_FFEF, 1'b0, 3);
    tv("sh_1ffc",   1'b1, 2'b01, 1'b0, 32'h1FFC, 32'h5555_1234, 32'h0, 1'b0, 4);
    tv("lw_1ffc_b", 1'b0, 2'b10, 1'b0, 32'h1FFC, 32'h0, 32'hDEAD_1234, 1'b0, 3);

    // Rejected requests
    tv("err_sh_101", 1'b1, 2'b01, 1'b0, 32'h101,  32'h5555, 32'h0, 1'b1, 1);
    tv("err_lw_102", 1'b0, 2'b10, 1'b0, 32'h102,  32'h0,    32'h0, 1'b1, 1);
    tv("err_sz11",   1'b0, 2'b11, 1'b0, 32'h100,  32'h0,    32'h0, 1'b1, 1);
    tv("err_range",  1'b0, 2'b10, 1'b0, 32'h2000, 32'h0,    32'h0, 1'b1, 1);
    check("err.bram_100", bram[32'h40], 32'h11AB_3344);

    // Reset during the WRITE cycle of a byte store
    wc = wren_cnt;
    rc = resp_cnt;
    issue(1'b1, 2'b00, 1'b0, 32'h100, 32'h0000_0055);
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort.req_ready", 32'(bus.req_ready), 1);
    repeat (6) @(posedge clk);
    #1;
    check("abort.no_write", wren_cnt, wc);
    check("abort.no_resp", resp_cnt, rc);
    check("abort.bram", bram[32'h40], 32'h11AB_3344);

    // Back-to-back alternating loads and stores with req_valid held high
    rc = resp_cnt;
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    issue(1'b1, 2'b00, 1'b0, 32'h101, 32'h0000_0077);
    issue(1'b0, 2'b01, 1'b0, 32'h100, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'h200, 32'h0BAD_F00D);
    issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_CAFE);
    bus.req_valid = 1'b0;
    wait_resp(rc + 6);
    repeat (3) @(posedge clk);
    #1;
    check("stream.resp_count", resp_cnt - rc, 6);
    check("stream.bram_100", bram[32'h40], 32'h11AB_7744);
    check("stream.bram_200", bram[32'h80], 32'hCAFE_F00D);
    tv("stream.lh_u_100", 1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 32'h0000_7744, 1'b0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
